// File: rtl/uart_bus_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_bus_sched_pkg : shared types and constants for the UART bus scheduler
// Revision: 1.0
// ----------------------------------------------------------------------------
package uart_bus_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_t;

    localparam int RX_ERR_PARITY  = 0;
    localparam int RX_ERR_FRAMING = 1;

    localparam int               OVF_W   = 8;
    localparam logic [OVF_W-1:0] OVF_MAX = '1;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (v == OVF_MAX) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bus_sched_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rr_arbiter : picks the first valid requester at or after the pointer
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_rot;
    logic [PTR_W:0]     w_sum;

    // Rotate so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        w_rot = NUM_REQ'({i_valid, i_valid} >> i_ptr);
        w_sum = '0;
        o_any = 1'b0;
        o_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_any && w_rot[k]) begin
                o_any = 1'b1;
                w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
                if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                    w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
                end
                o_idx = PTR_W'(w_sum);
            end
        end
        o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/uart_bus_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_bus_sched : sole master of the UART core strobes; round-robin TX, RX drain
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_bus_sched
    import uart_bus_sched_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rx_valid,
    output logic [7:0]             rx_data,
    output logic [1:0]             rx_err,
    input  logic                   rx_ready,
    output logic [OVF_W-1:0]       ovf_count,
    output logic                   UART_CSN,
    output logic                   UART_WEN,
    output logic                   UART_OEN,
    output logic [7:0]             UART_DATA_IN,
    input  logic [7:0]             UART_DATA_OUT,
    input  logic                   UART_TXRDY,
    input  logic                   UART_RXRDY,
    input  logic                   UART_PARITY_ERR,
    input  logic                   UART_FRAMING_ERR,
    input  logic                   UART_OVERFLOW
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_t       state_q, state_d;
    logic [2:0]         gap_q, gap_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_idx_q, grant_idx_d;
    logic               csn_q, csn_d, wen_q, wen_d, oen_q, oen_d;
    logic [7:0]         data_in_q, data_in_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               rx_valid_q, rx_valid_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic [1:0]         rx_err_q, rx_err_d;
    logic               ovf_s_q, ovf_s_d, ovf_p_q, ovf_p_d;
    logic [OVF_W-1:0]   ovf_count_q, ovf_count_d;

    logic [NUM_REQ-1:0] w_grant_oh;
    logic [PTR_W-1:0]   w_grant_idx;
    logic               w_grant_any;
    logic [7:0]         w_grant_byte;
    logic               w_rx_free;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_valid (req_valid),
        .i_ptr   (rr_ptr_q),
        .o_grant (w_grant_oh),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    always_comb begin
        w_grant_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_oh[i]) w_grant_byte = req_data[8*i +: 8];
        end
    end

    assign w_rx_free = !rx_valid_q || rx_ready;

    // Strobes are computed one cycle ahead so they are flop outputs in WRITE/READ.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        csn_d       = 1'b1;
        wen_d       = 1'b1;
        oen_d       = 1'b1;
        data_in_d   = data_in_q;
        req_ready_d = '0;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        rx_err_d    = rx_err_q;

        case (state_q)
            ST_IDLE: begin
                if (UART_RXRDY && w_rx_free) begin
                    state_d = ST_READ;
                    csn_d   = 1'b0;
                    oen_d   = 1'b0;
                end else if (UART_TXRDY && w_grant_any) begin
                    state_d     = ST_WRITE;
                    csn_d       = 1'b0;
                    wen_d       = 1'b0;
                    data_in_d   = w_grant_byte;
                    req_ready_d = w_grant_oh;
                    grant_idx_d = w_grant_idx;
                end
            end
            ST_WRITE: begin
                rr_ptr_d = (grant_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
                gap_d    = '0;
                state_d  = ST_GAP;
            end
            ST_READ: begin
                gap_d   = '0;
                state_d = ST_GAP;
            end
            default: begin
                if (gap_q == 3'(GAP_CYCLES - 1)) state_d = ST_IDLE;
                else                             gap_d   = gap_q + 3'd1;
            end
        endcase

        if (state_q == ST_READ) begin
            rx_valid_d                = 1'b1;
            rx_data_d                 = UART_DATA_OUT;
            rx_err_d[RX_ERR_FRAMING]  = UART_FRAMING_ERR;
            rx_err_d[RX_ERR_PARITY]   = UART_PARITY_ERR;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        ovf_s_d     = UART_OVERFLOW;
        ovf_p_d     = ovf_s_q;
        ovf_count_d = (ovf_s_q && !ovf_p_q) ? sat_inc(ovf_count_q) : ovf_count_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            oen_q       <= 1'b1;
            data_in_q   <= 8'h00;
            req_ready_q <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_err_q    <= 2'b00;
            ovf_s_q     <= 1'b0;
            ovf_p_q     <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            csn_q       <= csn_d;
            wen_q       <= wen_d;
            oen_q       <= oen_d;
            data_in_q   <= data_in_d;
            req_ready_q <= req_ready_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rx_err_q    <= rx_err_d;
            ovf_s_q     <= ovf_s_d;
            ovf_p_q     <= ovf_p_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign UART_CSN     = csn_q;
    assign UART_WEN     = wen_q;
    assign UART_OEN     = oen_q;
    assign UART_DATA_IN = data_in_q;
    assign req_ready    = req_ready_q;
    assign rx_valid     = rx_valid_q;
    assign rx_data      = rx_data_q;
    assign rx_err       = rx_err_q;
    assign ovf_count    = ovf_count_q;

endmodule
`default_nettype wire

// File: doc/uart_bus_sched.md
Name: uart_bus_sched

Overview:
- Scheduler that owns the UART core's single-byte register interface (CSN/WEN/OEN, DATA_IN/DATA_OUT, TXRDY/RXRDY, error flags).
- Shares the transmit side round-robin between NUM_REQ byte-stream requesters.
- Drains received bytes, with their error status, into one valid/ready stream.
- Sits between the UART core and the system-side producers/consumers; it is the only master of the core's strobes.

Parameters:
NUM_REQ, 2, number of transmit requesters (1..8)
GAP_CYCLES, 2, idle cycles after every UART access before TXRDY/RXRDY are re-sampled (covers flag-update latency, 1..7)

Ports:
CLK  in  1  system clock, same clock as UART core
RESET_N  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte, requester i at [8i+7:8i]
req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
rx_valid  out  1  received byte available
rx_data  out  8  received byte
rx_err  out  2  {framing, parity} captured with the byte
rx_ready  in  1  consumer accepts rx byte
ovf_count  out  8  saturating count of UART OVERFLOW rising edges
UART_CSN  out  1  core chip select, active low
UART_WEN  out  1  core write enable, active low
UART_OEN  out  1  core read enable, active low
UART_DATA_IN  out  8  byte to core
UART_DATA_OUT  in  8  byte from core
UART_TXRDY  in  1  core can accept a byte
UART_RXRDY  in  1  core holds a byte
UART_PARITY_ERR  in  1  core parity error
UART_FRAMING_ERR  in  1  core framing error
UART_OVERFLOW  in  1  core overflow

Behaviour:
- Reset: CSN/WEN/OEN = 1; UART_DATA_IN = 0; req_ready = 0; rx_valid = 0; rx_data = 0; rx_err = 0; ovf_count = 0; RR pointer = 0; state = IDLE.
- All UART_* outputs and req_ready are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, WRITE, READ, GAP.
- IDLE, evaluated in priority order:
  - If UART_RXRDY=1 and rx slot free (rx_valid=0, or rx_valid & rx_ready this cycle), go to READ.
  - Else if UART_TXRDY=1 and any req_valid, grant the first valid requester at or after the RR pointer (wrapping NUM_REQ-1 -> 0) and go to WRITE.
  - Else stay in IDLE.
  - RX has priority to avoid core overflow.
- WRITE (1 cycle):
  - CSN=0, WEN=0, OEN=1, DATA_IN = granted byte.
  - req_ready[grant]=1 this cycle; the requester drops or advances its data next cycle.
  - RR pointer <= grant+1 mod NUM_REQ.
  - Next state: GAP.
- READ (1 cycle):
  - CSN=0, OEN=0, WEN=1.
  - Same cycle: rx_data <= UART_DATA_OUT; rx_err <= {UART_FRAMING_ERR, UART_PARITY_ERR}; rx_valid <= 1.
  - Next state: GAP.
- GAP: strobes high; counts GAP_CYCLES cycles, then returns to IDLE. Write-to-write latency is therefore 1+GAP_CYCLES+1 cycles minimum.
- rx slot:
  - Single register; rx_valid clears on rx_valid & rx_ready unless a READ loads it the same cycle, in which case it stays 1 with new data.
  - rx_data and rx_err hold stable while rx_valid=1 and rx_ready=0.
- Backpressure: rx slot full with UART_RXRDY=1 means the scheduler does not read; TX writes continue; core overflow may result and is counted.
- ovf_count: increments on 0->1 of the registered UART_OVERFLOW; saturates at 255; no wrap.
- A requester whose req_valid drops before grant is simply skipped; grant decisions use only the IDLE-cycle samples.
- Reset asserted mid-access: strobes return high asynchronously; the in-flight byte is lost (the requester saw no req_ready, or already saw it).

Decomposition:
- Shared package: FSM state encoding (IDLE/WRITE/READ/GAP), rx_err bit indices, ovf_count width constant.
- One sub-module: uart_rr_arbiter (NUM_REQ valid vector + pointer in -> one-hot grant + index out, combinational).

Test Plan:
- Single requester 0 sends 0xA5, TXRDY=1 -> one WRITE cycle with CSN=0/WEN=0, DATA_IN=0xA5, req_ready=2'b01; next strobe no earlier than 4 cycles later (GAP_CYCLES=2).
- Both requesters valid continuously (0x11, 0x22), TXRDY=1 -> grants alternate 0,1,0,1; DATA_IN sequence 0x11,0x22,0x11,0x22.
- RXRDY=1 and TXRDY=1 with req_valid=1 in the same IDLE cycle -> READ first, WRITE after the GAP; rx_data=DATA_OUT (0x3C).
- Byte 0x7F with PARITY_ERR=1 read -> rx_valid=1, rx_data=0x7F, rx_err=2'b01; with rx_ready=0 held 10 cycles -> no further READ despite RXRDY=1, data stable.
- Toggle UART_OVERFLOW 300 times -> ovf_count saturates at 255.
- Assert RESET_N=0 during WRITE -> strobes high immediately, all outputs at reset values, RR pointer = 0 after release.
